mc_deadtime_gate: RTL and testbench

- Downstream of the motor-controller core. Consumes its raw commutation/PWM switch requests (VH/VL, 3 phases) and produces the gate-drive pins.
- Per phase, guarantees a programmable dead time (both switches off) between any high-side/low-side handover.
- Blocks illegal simultaneous high+low requests.
- Latches an external over-current fault that forces every gate off until software clears it.

---
 rtl/mc_gate_pkg.sv | 28 ++
 rtl/mc_deadtime_phase.sv | 113 +++++++++++
 rtl/mc_deadtime_gate.sv | 81 ++++++++
 tb/tb_mc_deadtime_gate.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_gate_pkg.sv
// Shared types and helpers for the three-phase dead-time gate driver.
// Optional minimum on-time (MC_MIN_ON_EN) is handled in mc_deadtime_phase.
package mc_gate_pkg;

    localparam int NPH = 3;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        H_ON = 2'd1,
        L_ON = 2'd2,
        DEAD = 2'd3
    } ph_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } req_t;

    // A disabled block or a simultaneous high+low request both decode as "neither".
    function automatic req_t decode_req(input logic en, input logic vh, input logic vl);
        if (!en || (vh == vl)) begin
            return NONE;
        end
        return vh ? HIGH : LOW;
    endfunction

endpackage

// File: rtl/mc_deadtime_phase.sv
// One half-bridge: OFF/H_ON/L_ON/DEAD FSM with dead counter and registered gates.
// With MC_MIN_ON_EN defined, an on-timer holds H_ON/L_ON for at least MIN_ON cycles.
module mc_deadtime_phase
    import mc_gate_pkg::*;
#(
    parameter int DT_W   = 8,
    parameter int MIN_ON = 4
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  req_t            i_req,
    input  logic            i_force,
    input  logic [DT_W-1:0] i_dt,
    output logic            o_gh,
    output logic            o_gl
);

    ph_state_t       r_state;
    ph_state_t       w_state_nxt;
    logic [DT_W-1:0] r_cnt;
    logic [DT_W-1:0] w_cnt_nxt;
    logic            r_gh;
    logic            r_gl;
    logic            w_gh_nxt;
    logic            w_gl_nxt;

`ifdef MC_MIN_ON_EN
    localparam int ON_W = (MIN_ON > 2) ? $clog2(MIN_ON) : 1;
    logic [ON_W-1:0] r_ontmr;
    logic [ON_W-1:0] w_ontmr_nxt;
    logic            w_hold;

    assign w_hold = (r_ontmr != '0);
`else
    logic w_unused_min_on;
    assign w_unused_min_on = (MIN_ON != 0);
`endif

    // Gates are registered from the next state so they never glitch on state decode.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= OFF;
            r_cnt   <= '0;
            r_gh    <= 1'b0;
            r_gl    <= 1'b0;
`ifdef MC_MIN_ON_EN
            r_ontmr <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gh    <= w_gh_nxt;
            r_gl    <= w_gl_nxt;
`ifdef MC_MIN_ON_EN
            r_ontmr <= w_ontmr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_force) begin
            w_state_nxt = DEAD;
            w_cnt_nxt   = i_dt;
        end else begin
            unique case (r_state)
                OFF, DEAD: begin
                    if ((r_state == DEAD) && (r_cnt != '0)) begin
                        w_cnt_nxt = r_cnt - DT_W'(1);
                    end else begin
                        case (i_req)
                            HIGH:    w_state_nxt = H_ON;
                            LOW:     w_state_nxt = L_ON;
                            default: w_state_nxt = OFF;
                        endcase
                    end
                end
                H_ON, L_ON: begin
`ifdef MC_MIN_ON_EN
                    if (!w_hold && (i_req != ((r_state == H_ON) ? HIGH : LOW))) begin
`else
                    if (i_req != ((r_state == H_ON) ? HIGH : LOW)) begin
`endif
                        w_state_nxt = DEAD;
                        w_cnt_nxt   = i_dt;
                    end
                end
                default: w_state_nxt = OFF;
            endcase
        end
    end

`ifdef MC_MIN_ON_EN
    always_comb begin
        w_ontmr_nxt = r_ontmr;
        if ((w_state_nxt == H_ON || w_state_nxt == L_ON) && (w_state_nxt != r_state)) begin
            w_ontmr_nxt = ON_W'(MIN_ON - 1);
        end else if (w_hold) begin
            w_ontmr_nxt = r_ontmr - ON_W'(1);
        end
    end
`endif

    always_comb begin
        w_gh_nxt = (w_state_nxt == H_ON);
        w_gl_nxt = (w_state_nxt == L_ON);
    end

    assign o_gh = r_gh;
    assign o_gl = r_gl;

endmodule

// File: rtl/mc_deadtime_gate.sv
// Three-phase dead-time gate driver: request decode, shoot-through flags, fault latch.
// Define MC_MIN_ON_EN to enforce a minimum gate on-time of MIN_ON cycles.
module mc_deadtime_gate
    import mc_gate_pkg::*;
#(
    parameter int DT_W   = 8,
    parameter int MIN_ON = 4
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            en,
    input  logic [DT_W-1:0] dt_cycles,
    input  logic [NPH-1:0]  VH_in,
    input  logic [NPH-1:0]  VL_in,
    input  logic            fault_n,
    input  logic            fault_clr,
    output logic [NPH-1:0]  GH,
    output logic [NPH-1:0]  GL,
    output logic            fault_latched,
    output logic [NPH-1:0]  shoot_err
);

    logic [1:0]     r_fault_sync;
    logic           r_fault_latched;
    logic [NPH-1:0] r_shoot_err;
    logic           w_fault_active;
    logic           w_force;
    req_t           w_req [NPH];

    // Synchronizer idles high so reset never looks like a fault.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fault_sync <= 2'b11;
        end else begin
            r_fault_sync <= {r_fault_sync[0], fault_n};
        end
    end

    assign w_fault_active = ~r_fault_sync[1];
    // The raw synchronized fault also forces DEAD so gates fall alongside the latch.
    assign w_force        = r_fault_latched | w_fault_active;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_fault_latched <= 1'b0;
            r_shoot_err     <= '0;
        end else begin
            if (w_fault_active) begin
                r_fault_latched <= 1'b1;
            end else if (fault_clr) begin
                r_fault_latched <= 1'b0;
            end
            r_shoot_err <= (fault_clr ? '0 : r_shoot_err) | ({NPH{en}} & VH_in & VL_in);
        end
    end

    always_comb begin
        for (int i = 0; i < NPH; i++) begin
            w_req[i] = decode_req(en, VH_in[i], VL_in[i]);
        end
    end

    for (genvar g = 0; g < NPH; g++) begin : g_phase
        mc_deadtime_phase #(
            .DT_W   (DT_W),
            .MIN_ON (MIN_ON)
        ) u_phase (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .i_req   (w_req[g]),
            .i_force (w_force),
            .i_dt    (dt_cycles),
            .o_gh    (GH[g]),
            .o_gl    (GL[g])
        );
    end

    assign fault_latched = r_fault_latched;
    assign shoot_err     = r_shoot_err;

endmodule

// File: tb/tb_mc_deadtime_gate.sv
// Directed and randomized bench for mc_deadtime_gate against a per-phase gate/dead-time model.
module tb_mc_deadtime_gate;

    localparam int DT_W   = 8;
    localparam int MIN_ON = 4;
`ifdef MC_MIN_ON_EN
    localparam int HOLD = MIN_ON - 1;
`else
    localparam int HOLD = 0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            en;
    logic [DT_W-1:0] dt_cycles;
    logic [2:0]      VH_in;
    logic [2:0]      VL_in;
    logic            fault_n;
    logic            fault_clr;
    logic [2:0]      GH;
    logic [2:0]      GL;
    logic            fault_latched;
    logic [2:0]      shoot_err;

    int checks   = 0;
    int failures = 0;

    // Model: which gate is on (0 none, 1 high, 2 low), remaining extra dead cycles (-1 = not dead),
    // remaining forced hold cycles of the on-time.
    int         m_on   [3];
    int         m_dead [3];
    int         m_hold [3];
    logic       m_s0, m_s1, m_lat;
    logic [2:0] m_sh;

    always #5 HCLK = ~HCLK;

    mc_deadtime_gate #(
        .DT_W   (DT_W),
        .MIN_ON (MIN_ON)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .en            (en),
        .dt_cycles     (dt_cycles),
        .VH_in         (VH_in),
        .VL_in         (VL_in),
        .fault_n       (fault_n),
        .fault_clr     (fault_clr),
        .GH            (GH),
        .GL            (GL),
        .fault_latched (fault_latched),
        .shoot_err     (shoot_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_on[i]   = 0;
            m_dead[i] = -1;
            m_hold[i] = 0;
        end
        m_s0  = 1'b1;
        m_s1  = 1'b1;
        m_lat = 1'b0;
        m_sh  = '0;
    endtask

    task automatic model_step();
        logic frc;
        int   req;
        if (!HRESETn) begin
            model_reset();
            return;
        end
        frc = m_lat | ~m_s1;
        for (int i = 0; i < 3; i++) begin
            if (!en || (VH_in[i] == VL_in[i])) req = 0;
            else req = VH_in[i] ? 1 : 2;
            if (frc) begin
                m_on[i]   = 0;
                m_dead[i] = int'(dt_cycles);
            end else if (m_dead[i] > 0) begin
                m_dead[i]--;
            end else if (m_dead[i] == 0 || m_on[i] == 0) begin
                m_dead[i] = -1;
                m_on[i]   = req;
                m_hold[i] = HOLD;
            end else if (m_hold[i] > 0) begin
                m_hold[i]--;
            end else if (req != m_on[i]) begin
                m_on[i]   = 0;
                m_dead[i] = int'(dt_cycles);
            end
        end
        if (fault_clr) m_sh = '0;
        if (en) m_sh = m_sh | (VH_in & VL_in);
        if (!m_s1) m_lat = 1'b1;
        else if (fault_clr) m_lat = 1'b0;
        m_s1 = m_s0;
        m_s0 = fault_n;
    endtask

    task automatic compare_all();
        logic [2:0] egh, egl;
        for (int i = 0; i < 3; i++) begin
            egh[i] = (m_on[i] == 1);
            egl[i] = (m_on[i] == 2);
        end
        chk("GH", 32'(GH), 32'(egh));
        chk("GL", 32'(GL), 32'(egl));
        chk("fault_latched", 32'(fault_latched), 32'(m_lat));
        chk("shoot_err", 32'(shoot_err), 32'(m_sh));
        chk("no_overlap", 32'(GH & GL), 32'd0);
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        int off;
        HRESETn   = 1'b0;
        en        = 1'b1;
        dt_cycles = 8'd5;
        VH_in     = '0;
        VL_in     = '0;
        fault_n   = 1'b1;
        fault_clr = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        HRESETn = 1'b1;
        tick();

        // dt=5: high for 20 cycles then low, expect 6 both-off cycles
        VH_in = 3'b001;
        tick();
        chk("gh0_after_req", 32'(GH[0]), 32'd1);
        repeat (19) tick();
        VH_in = 3'b000;
        VL_in = 3'b001;
        n = 0;
        tick();
        while (GL[0] !== 1'b1 && n < 40) begin
            if (GH[0] === 1'b0) n++;
            tick();
        end
        chk("dead_len_dt5", 32'(n), 32'd6);

        // dt=0: alternate every 3 cycles, one both-off cycle per switch
        dt_cycles = 8'd0;
        for (int k = 0; k < 6; k++) begin
            VH_in = (k % 2 == 0) ? 3'b001 : 3'b000;
            VL_in = (k % 2 == 0) ? 3'b000 : 3'b001;
            off = 0;
            repeat (3) begin
                tick();
                if (GH[0] === 1'b0 && GL[0] === 1'b0) off++;
            end
            chk("dead_len_dt0", 32'(off), 32'd1);
        end

        // shoot-through request on phase1 while it is on
        VH_in = 3'b010;
        VL_in = 3'b000;
        dt_cycles = 8'd3;
        repeat (6) tick();
        VL_in = 3'b010;
        tick();
        chk("shoot_set", 32'(shoot_err), 32'b010);
        chk("shoot_gh1_off", 32'(GH[1]), 32'd0);
        VL_in = 3'b000;
        repeat (6) tick();
        chk("shoot_sticky", 32'(shoot_err), 32'b010);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("shoot_cleared", 32'(shoot_err), 32'b000);

        // fault with all phases on
        dt_cycles = 8'd2;
        VH_in = 3'b101;
        VL_in = 3'b010;
        repeat (8) tick();
        chk("all_on", 32'(GH | GL), 32'b111);
        fault_n = 1'b0;
        repeat (3) tick();
        chk("fault_gates_off", 32'(GH | GL), 32'b000);
        chk("fault_set", 32'(fault_latched), 32'd1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_clr_ignored", 32'(fault_latched), 32'd1);
        fault_n = 1'b1;
        repeat (3) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_cleared", 32'(fault_latched), 32'd0);
        n = 0;
        while ((GH | GL) === 3'b000 && n < 40) begin
            tick();
            n++;
        end
        chk("fault_recover_len", 32'(n), 32'(int'(dt_cycles) + 1));

        // en dropped with dt=10, then reset mid-DEAD
        dt_cycles = 8'd10;
        VH_in = 3'b011;
        VL_in = 3'b011;
        tick();
        VL_in = 3'b100;
        VH_in = 3'b001;
        repeat (14) tick();
        en = 1'b0;
        repeat (5) tick();
        chk("en_off_gates", 32'(GH | GL), 32'b000);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("reset_shoot", 32'(shoot_err), 32'b000);
        tick();
        #2;
        HRESETn = 1'b1;
        en = 1'b1;

        // randomized traffic
        VH_in = '0;
        VL_in = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0) dt_cycles = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) VH_in = 3'($urandom);
            if ($urandom_range(0, 3) == 0) VL_in = 3'($urandom) & ~(($urandom_range(0, 3) != 0) ? VH_in : 3'b000);
            en        = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 59) == 0) fault_n = ~fault_n;
            fault_clr = ($urandom_range(0, 9) == 0);
            tick();
        end

        // async reset with gates on
        fault_n   = 1'b1;
        fault_clr = 1'b0;
        en        = 1'b1;
        repeat (4) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        VH_in = 3'b111;
        VL_in = 3'b000;
        repeat (12) tick();
        chk("pre_reset_on", 32'(GH), 32'b111);
        #2;
        HRESETn = 1'b0;
        model_reset();
        #1;
        chk("reset_gh_async", 32'(GH), 32'b000);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
